// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA descriptor scheduler.
// Holds the FSM state encoding and the default counter widths.
package dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_WAIT,
    ST_DONE
  } dma_state_e;

  localparam int DMA_NUM_DESC_DEF = 8;
  localparam int DMA_LOOP_CNT_W   = 8;
  localparam int DMA_XFER_CNT_W   = 16;

  function automatic int dma_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dma_desc_sched.sv
// DMA descriptor scheduler: walks a wrap-capable descriptor range and
// issues one-cycle slice requests for each enabled descriptor.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   csr_*              start/abort/irq-clear and range/enable/loop config
//   dma_slice_idx/valid  slice request; dma_slice_done  slice completion
//   dma_busy/done/irq/aborted  status; dma_cur_idx/pass_cnt/xfer_cnt  progress
module dma_desc_sched
  import dma_pkg::*;
#(
  parameter int DMA_NUM_DESC   = DMA_NUM_DESC_DEF,
  parameter int DESC_IDX_WIDTH = dma_idx_w(DMA_NUM_DESC),
  parameter int LOOP_CNT_WIDTH = DMA_LOOP_CNT_W,
  parameter int XFER_CNT_WIDTH = DMA_XFER_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      csr_dma_start,
  input  logic                      csr_dma_abort,
  input  logic                      csr_irq_clr,
  input  logic [DESC_IDX_WIDTH-1:0] csr_desc_first,
  input  logic [DESC_IDX_WIDTH-1:0] csr_desc_last,
  input  logic [DMA_NUM_DESC-1:0]   csr_desc_enable,
  input  logic [LOOP_CNT_WIDTH-1:0] csr_dma_loop_cnt,
  output logic [DESC_IDX_WIDTH-1:0] dma_slice_idx,
  output logic                      dma_slice_valid,
  input  logic                      dma_slice_done,
  output logic                      dma_busy,
  output logic                      dma_done,
  output logic                      dma_irq,
  output logic                      dma_aborted,
  output logic [DESC_IDX_WIDTH-1:0] dma_cur_idx,
  output logic [LOOP_CNT_WIDTH-1:0] dma_pass_cnt,
  output logic [XFER_CNT_WIDTH-1:0] dma_xfer_cnt
);

  dma_state_e                r_state;
  logic [DESC_IDX_WIDTH-1:0] r_first;
  logic [DESC_IDX_WIDTH-1:0] r_last;
  logic [DMA_NUM_DESC-1:0]   r_en;
  logic [LOOP_CNT_WIDTH-1:0] r_loop;
  logic [DESC_IDX_WIDTH-1:0] r_cur;
  logic [LOOP_CNT_WIDTH-1:0] r_pass;
  logic [XFER_CNT_WIDTH-1:0] r_xfer;
  logic                      r_valid;
  logic                      r_irq;
  logic                      r_aborted;
  logic                      r_abort_pend;

  logic                      w_at_last;
  logic                      w_last_pass;
  logic                      w_final;

  assign w_at_last   = (r_cur == r_last);
  assign w_last_pass = (r_pass == r_loop);
  // Completion of the last descriptor on the last pass beats any abort.
  assign w_final     = w_at_last && w_last_pass;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_first      <= '0;
      r_last       <= '0;
      r_en         <= '0;
      r_loop       <= '0;
      r_cur        <= '0;
      r_pass       <= '0;
      r_xfer       <= '0;
      r_valid      <= 1'b0;
      r_irq        <= 1'b0;
      r_aborted    <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      // Clear first so any set below in the same cycle wins.
      if (csr_irq_clr) begin
        r_irq     <= 1'b0;
        r_aborted <= 1'b0;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (csr_dma_start) begin
            r_first      <= csr_desc_first;
            r_last       <= csr_desc_last;
            r_en         <= csr_desc_enable;
            r_loop       <= csr_dma_loop_cnt;
            r_cur        <= csr_desc_first;
            r_pass       <= '0;
            r_xfer       <= '0;
            r_aborted    <= 1'b0;
            r_abort_pend <= 1'b0;
            r_state      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (csr_dma_abort) begin
            r_aborted <= 1'b1;
            r_state   <= ST_DONE;
          end else if (r_en[r_cur]) begin
            r_valid <= 1'b1;
            r_state <= ST_WAIT;
          end else if (w_at_last) begin
            if (w_last_pass) begin
              r_state <= ST_DONE;
            end else begin
              r_pass <= r_pass + 1'b1;
              r_cur  <= r_first;
            end
          end else begin
            r_cur <= r_cur + 1'b1;
          end
        end
        ST_WAIT: begin
          if (dma_slice_done) begin
            r_xfer <= r_xfer + 1'b1;
            if (w_final) begin
              r_state <= ST_DONE;
            end else if (csr_dma_abort || r_abort_pend) begin
              r_aborted <= 1'b1;
              r_state   <= ST_DONE;
            end else if (w_at_last) begin
              r_pass  <= r_pass + 1'b1;
              r_cur   <= r_first;
              r_state <= ST_SCAN;
            end else begin
              r_cur   <= r_cur + 1'b1;
              r_state <= ST_SCAN;
            end
          end else if (csr_dma_abort) begin
            // The running slice is never cut short; abort once it ends.
            r_abort_pend <= 1'b1;
          end
        end
        ST_DONE: begin
          r_irq        <= 1'b1;
          r_abort_pend <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dma_slice_idx   = r_cur;
  assign dma_slice_valid = r_valid;
  assign dma_busy        = (r_state != ST_IDLE);
  assign dma_done        = (r_state == ST_DONE);
  assign dma_irq         = r_irq;
  assign dma_aborted     = r_aborted;
  assign dma_cur_idx     = r_cur;
  assign dma_pass_cnt    = r_pass;
  assign dma_xfer_cnt    = r_xfer;

endmodule

// File: tb/tb_dma_desc_sched.sv
// Scoreboard bench for dma_desc_sched: a slice responder pops the
// expected descriptor index on every valid and answers with done.
module tb_dma_desc_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_dma_start = 1'b0;
  logic        csr_dma_abort;
  logic        csr_irq_clr = 1'b0;
  logic [2:0]  csr_desc_first = '0;
  logic [2:0]  csr_desc_last = '0;
  logic [7:0]  csr_desc_enable = '0;
  logic [7:0]  csr_dma_loop_cnt = '0;
  logic [2:0]  dma_slice_idx;
  logic        dma_slice_valid;
  logic        dma_slice_done = 1'b0;
  logic        dma_busy;
  logic        dma_done;
  logic        dma_irq;
  logic        dma_aborted;
  logic [2:0]  dma_cur_idx;
  logic [7:0]  dma_pass_cnt;
  logic [15:0] dma_xfer_cnt;

  logic        main_abort = 1'b0;
  logic        sl_abort = 1'b0;
  logic        abort_at_done = 1'b0;
  assign csr_dma_abort = main_abort | sl_abort;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_done = 0;
  int sdone_cyc = 0;
  int vcyc_q[$];
  int exp_q[$];

  dma_desc_sched dut (
    .clk              (clk),
    .rst              (rst),
    .csr_dma_start    (csr_dma_start),
    .csr_dma_abort    (csr_dma_abort),
    .csr_irq_clr      (csr_irq_clr),
    .csr_desc_first   (csr_desc_first),
    .csr_desc_last    (csr_desc_last),
    .csr_desc_enable  (csr_desc_enable),
    .csr_dma_loop_cnt (csr_dma_loop_cnt),
    .dma_slice_idx    (dma_slice_idx),
    .dma_slice_valid  (dma_slice_valid),
    .dma_slice_done   (dma_slice_done),
    .dma_busy         (dma_busy),
    .dma_done         (dma_done),
    .dma_irq          (dma_irq),
    .dma_aborted      (dma_aborted),
    .dma_cur_idx      (dma_cur_idx),
    .dma_pass_cnt     (dma_pass_cnt),
    .dma_xfer_cnt     (dma_xfer_cnt)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial forever begin
    @(negedge clk);
    if (dma_done) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Slice model: 5-cycle service time after each valid.
  initial forever begin
    @(negedge clk);
    if (dma_slice_valid) begin
      n_valid++;
      vcyc_q.push_back(cyc);
      if (exp_q.size() == 0) chk("valid_unexp", 32'd1, 32'd0);
      else chk("slice_idx", 32'(dma_slice_idx), 32'(exp_q.pop_front()));
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (i == 0) chk("valid_width", 32'(dma_slice_valid), 32'd0);
      end
      dma_slice_done = 1'b1;
      sl_abort = abort_at_done;
      sdone_cyc = cyc;
      @(negedge clk);
      dma_slice_done = 1'b0;
      sl_abort = 1'b0;
    end
  end

  task automatic push_model(input int f, input int l,
                            input logic [7:0] en, input int lp);
    for (int p = 0; p <= lp; p++) begin
      for (int k = 0; k < 8; k++) begin
        int idx;
        idx = (f + k) % 8;
        if (en[idx]) exp_q.push_back(idx);
        if (idx == l) break;
      end
    end
  endtask

  function automatic int range_len(input int f, input int l);
    return ((l - f + 8) % 8) + 1;
  endfunction

  task automatic run_start(input int f, input int l, input logic [7:0] en,
                           input int lp, output int t0);
    @(negedge clk);
    csr_desc_first   = 3'(f);
    csr_desc_last    = 3'(l);
    csr_desc_enable  = en;
    csr_dma_loop_cnt = 8'(lp);
    csr_dma_start    = 1'b1;
    @(negedge clk);
    csr_dma_start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (dma_done) begin
        dc = cyc;
        break;
      end
    end
    chk("done_seen", 32'(dc >= 0), 32'd1);
  endtask

  task automatic wait_valids(input int nv0, input int want);
    int ok;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      if (n_valid - nv0 >= want) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("valid_seen", 32'(ok), 32'd1);
  endtask

  task automatic irq_clear();
    @(negedge clk);
    csr_irq_clr = 1'b1;
    @(negedge clk);
    csr_irq_clr = 1'b0;
  endtask

  initial begin
    int t0, dc, nv0, nd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(dma_busy), 0);
    chk("rst_valid", 32'(dma_slice_valid), 0);
    chk("rst_done", 32'(dma_done), 0);
    chk("rst_irq", 32'(dma_irq), 0);
    chk("rst_abrt", 32'(dma_aborted), 0);
    chk("rst_cur", 32'(dma_cur_idx), 0);
    chk("rst_pass", 32'(dma_pass_cnt), 0);
    chk("rst_xfer", 32'(dma_xfer_cnt), 0);
    rst = 1'b0;

    // Single range 2..4
    nv0 = n_valid; nd0 = n_done;
    push_model(2, 4, 8'hFF, 0);
    run_start(2, 4, 8'hFF, 0, t0);
    chk("t1_busy", 32'(dma_busy), 1);
    wait_done(dc);
    chk("t1_xfer", 32'(dma_xfer_cnt), 3);
    chk("t1_pass", 32'(dma_pass_cnt), 0);
    @(negedge clk);
    chk("t1_done1cyc", 32'(dma_done), 0);
    chk("t1_ndone", 32'(n_done - nd0), 1);
    chk("t1_irq", 32'(dma_irq), 1);
    chk("t1_idle", 32'(dma_busy), 0);
    chk("t1_nvalid", 32'(n_valid - nv0), 3);
    chk("t1_sb", 32'(exp_q.size()), 0);
    irq_clear();
    chk("t1_irqclr", 32'(dma_irq), 0);

    // Skip and wrap 6..1
    nv0 = n_valid;
    vcyc_q.delete();
    push_model(6, 1, 8'b0100_0001, 0);
    run_start(6, 1, 8'b0100_0001, 0, t0);
    wait_done(dc);
    chk("t2_xfer", 32'(dma_xfer_cnt), 2);
    chk("t2_nv", 32'(vcyc_q.size()), 2);
    if (vcyc_q.size() > 0) chk("t2_lat", 32'(vcyc_q[0]), 32'(t0 + 1));
    chk("t2_sb", 32'(exp_q.size()), 0);

    // Loop 3..3 x3
    nv0 = n_valid;
    push_model(3, 3, 8'hFF, 2);
    run_start(3, 3, 8'hFF, 2, t0);
    wait_done(dc);
    chk("t3_pass", 32'(dma_pass_cnt), 2);
    chk("t3_xfer", 32'(dma_xfer_cnt), 3);
    chk("t3_nvalid", 32'(n_valid - nv0), 3);
    chk("t3_sb", 32'(exp_q.size()), 0);

    // Abort in WAIT on idx 1 of 0..3
    nv0 = n_valid;
    exp_q.push_back(0);
    exp_q.push_back(1);
    run_start(0, 3, 8'hFF, 0, t0);
    wait_valids(nv0, 2);
    main_abort = 1'b1;
    @(negedge clk);
    main_abort = 1'b0;
    wait_done(dc);
    chk("t4_donecyc", 32'(dc), 32'(sdone_cyc + 1));
    chk("t4_abrt", 32'(dma_aborted), 1);
    chk("t4_xfer", 32'(dma_xfer_cnt), 2);
    repeat (10) @(negedge clk);
    chk("t4_nvalid", 32'(n_valid - nv0), 2);
    chk("t4_sb", 32'(exp_q.size()), 0);
    irq_clear();
    chk("t4_abrtclr", 32'(dma_aborted), 0);

    // Abort coincident with final done
    abort_at_done = 1'b1;
    push_model(5, 5, 8'hFF, 0);
    run_start(5, 5, 8'hFF, 0, t0);
    wait_done(dc);
    abort_at_done = 1'b0;
    chk("t5_abrt", 32'(dma_aborted), 0);
    chk("t5_xfer", 32'(dma_xfer_cnt), 1);
    chk("t5_sb", 32'(exp_q.size()), 0);

    // Empty range 1..5
    nv0 = n_valid;
    run_start(1, 5, 8'h00, 0, t0);
    wait_done(dc);
    chk("t6_donecyc", 32'(dc), 32'(t0 + range_len(1, 5)));
    chk("t6_nvalid", 32'(n_valid - nv0), 0);
    chk("t6_xfer", 32'(dma_xfer_cnt), 0);

    // Start while busy ignored
    nv0 = n_valid;
    push_model(0, 1, 8'hFF, 0);
    run_start(0, 1, 8'hFF, 0, t0);
    wait_valids(nv0, 1);
    csr_desc_first = 3'd4;
    csr_desc_last  = 3'd4;
    csr_dma_start  = 1'b1;
    @(negedge clk);
    csr_dma_start = 1'b0;
    wait_done(dc);
    chk("t7_xfer", 32'(dma_xfer_cnt), 2);
    chk("t7_cur", 32'(dma_cur_idx), 1);
    @(negedge clk);
    chk("t7_idle", 32'(dma_busy), 0);
    chk("t7_sb", 32'(exp_q.size()), 0);

    // irq_clr held across done: set wins
    irq_clear();
    chk("t8_pre", 32'(dma_irq), 0);
    push_model(2, 2, 8'hFF, 0);
    csr_irq_clr = 1'b1;
    run_start(2, 2, 8'hFF, 0, t0);
    wait_done(dc);
    @(negedge clk);
    chk("t8_irq", 32'(dma_irq), 1);
    csr_irq_clr = 1'b0;
    chk("t8_sb", 32'(exp_q.size()), 0);

    // Reset during WAIT
    nv0 = n_valid;
    exp_q.push_back(0);
    run_start(0, 3, 8'hFF, 0, t0);
    wait_valids(nv0, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t9_busy", 32'(dma_busy), 0);
    chk("t9_valid", 32'(dma_slice_valid), 0);
    chk("t9_irq", 32'(dma_irq), 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("t9_xfer", 32'(dma_xfer_cnt), 0);
    chk("t9_idle", 32'(dma_busy), 0);
    chk("t9_sb", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
